reg_file_2r1w: RTL
==================

# reg_file_2r1w

Parametrised successor to the single-port register file for the Mini SRC datapath. It has two combinational read ports (A and B), for the 3-bus datapath, and one synchronous write port. Optional same-cycle write-to-read bypass is provided. R0 reads as zero when the base-address select is asserted, as the ISA requires. Reset runs a hardware clear sequencer that zeroes every entry, because the array maps to on-chip memory and cannot be asynchronously reset.

## Interface
- `DEPTH`, 4: address width; the file holds 2^DEPTH entries.
- `WIDTH`, 32: data width in bits.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to a matching read port.
- `ZERO_R0`, 1: when 1, `ba_sel` forces port A to read 0 whenever `r_addr_a` = 0.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr_req` in 1: one-cycle pulse that starts a full array clear.
- `busy` out 1: high while the clear sequence runs.
- `wr_en` in 1: write enable.
- `w_addr` in DEPTH: write address.
- `w_data` in WIDTH: write data.
- `r_addr_a`, `r_addr_b` in DEPTH: read addresses.
- `ba_sel` in 1: base-address read on port A (R0 reads as zero).
- `r_data_a`, `r_data_b` out WIDTH: read data.

## Operation
- The FSM has two states, IDLE and CLEAR, plus a DEPTH-bit clear pointer `clr_ptr`.
- Reset (`rst_n` low) forces, asynchronously:
  - state = CLEAR, `clr_ptr` = 0, `busy` = 1;
  - `r_data_a` and `r_data_b` = 0.
  - Array contents are not reset directly.
- CLEAR, each rising edge:
  - writes 0 to `reg_array[clr_ptr]`, then increments `clr_ptr`;
  - on the edge that clears entry 2^DEPTH−1, goes to IDLE with `busy` = 0 and `clr_ptr` wrapped to 0.
- IDLE:
  - `wr_en` = 1 writes `w_data` to `w_addr` on the rising edge.
  - `clr_req` = 1 enters CLEAR on the next edge with `clr_ptr` = 0 and `busy` = 1.
- Reads are combinational:
  - `r_data_x` = `reg_array[r_addr_x]`.
  - With `BYPASS` = 1, `wr_en` = 1, state IDLE and `w_addr` = `r_addr_x`, then `r_data_x` = `w_data`.
  - With `ZERO_R0` = 1, `ba_sel` = 1 and `r_addr_a` = 0, then `r_data_a` = 0. This override has priority over bypass.
  - Port B ignores `ba_sel`.
- In CLEAR, both read ports return 0 and `wr_en` is ignored; the write is dropped, not queued.
- Boundary rules:
  - `clr_req` and `wr_en` in the same IDLE cycle: the clear wins and the write is dropped.
  - `clr_req` during CLEAR restarts the sweep at `clr_ptr` = 0.
  - `rst_n` asserted mid-clear or mid-write: immediate return to the CLEAR reset state. A write at the same edge as the reset assertion is lost.
  - Both read ports may address the same entry; they return identical data.
  - A write to R0 stores normally. Only a `ba_sel` read on port A masks it.

## Timing
- Read latency: 0 cycles (combinational from address, and from `w_data` when bypassing).
- Write latency: data is visible without bypass in the cycle after the write edge.
- Clear duration: exactly 2^DEPTH rising edges after `rst_n` deasserts or after the edge that samples `clr_req`. With defaults, `busy` falls after the 16th edge.
- `busy` is registered, with no combinational path from inputs.

## Structure
- Package `reg_file_pkg` holds:
  - the state enum (`RF_IDLE`, `RF_CLEAR`);
  - the default constants `RF_DEPTH` = 4 and `RF_WIDTH` = 32.
- Sub-module `reg_file_clr_seq` holds the FSM and `clr_ptr`. It outputs `busy`, `clr_we` and `clr_addr`.
- The top module holds the array, the write mux (clear versus user write), and the read/bypass/R0 logic. Target size is about 150–250 lines.

## Test plan
- Reset, release, then check `busy`:
  - `busy` = 1 and reads = 0 for 16 cycles;
  - `busy` = 0 after edge 16;
  - every address reads 0.
- Write R5 = 0xDEADBEEF and R9 = 0x12345678, then next cycle set `r_addr_a` = 5 and `r_addr_b` = 9 → both values returned.
- `BYPASS` = 1: `wr_en` with `w_addr` = 3, `w_data` = 0xA5A5A5A5 and `r_addr_b` = 3 in the same cycle → `r_data_b` = 0xA5A5A5A5 before the edge. With `BYPASS` = 0 → the old value.
- Write R0 = 0x0000FFFF:
  - `ba_sel` = 1, `r_addr_a` = 0 → 0;
  - `ba_sel` = 0 → 0x0000FFFF;
  - port B at address 0 → 0x0000FFFF.
- `clr_req` with a simultaneous write to R7 → write dropped, 16-cycle clear, R7 = 0. A second `clr_req` at cycle 8 of the clear → the sweep restarts and `busy` lasts 16 more cycles.
- `rst_n` pulsed low mid-clear (cycle 5) → `busy` stays 1, `clr_ptr` = 0, and the full 16-cycle sweep runs after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the 2R1W register file.
package reg_file_pkg;

  localparam int unsigned RF_DEPTH = 4;
  localparam int unsigned RF_WIDTH = 32;

  // Clear sequencer states; reset lands in RF_CLEAR so the array is swept after power-up.
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks a pointer over every entry, emitting a zero-write per edge.
import reg_file_pkg::*;

module reg_file_clr_seq #(
  parameter int unsigned DEPTH = RF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_we,
  output logic [DEPTH-1:0] clr_addr
);

  rf_state_e        state_q, state_d;
  logic [DEPTH-1:0] ptr_q, ptr_d;

  // State and pointer registers; reset starts a full sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: a request in either state (re)starts the sweep at entry 0.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        if (clr_req) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + DEPTH'(1);
          // Last entry cleared on this edge; pointer wraps back to 0.
          if (ptr_q == '1) state_d = RF_IDLE;
        end
      end
    endcase
  end

  // Outputs depend on registers only.
  assign busy     = (state_q == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two combinational read ports, one synchronous write port, with bypass and R0 masking.
import reg_file_pkg::*;

module reg_file_2r1w #(
  parameter int unsigned DEPTH   = RF_DEPTH,
  parameter int unsigned WIDTH   = RF_WIDTH,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             busy,
  input  logic             wr_en,
  input  logic [DEPTH-1:0] w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [DEPTH-1:0] r_addr_a,
  input  logic [DEPTH-1:0] r_addr_b,
  input  logic             ba_sel,
  output logic [WIDTH-1:0] r_data_a,
  output logic [WIDTH-1:0] r_data_b
);

  localparam int unsigned Entries = 1 << DEPTH;

  logic [WIDTH-1:0] reg_array [Entries];
  logic             clr_we;
  logic [DEPTH-1:0] clr_addr;
  logic             user_we;
  logic             byp_ok;

  reg_file_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A clear request beats a same-cycle write; rst_n gating drops a write racing reset.
  assign user_we = wr_en && !busy && !clr_req && rst_n;
  assign byp_ok  = (BYPASS != 0) && wr_en && !busy;

  // Array has no reset: it is zeroed by the clear sweep instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      reg_array[clr_addr] <= '0;
    end else if (user_we) begin
      reg_array[w_addr] <= w_data;
    end
  end

  // Port A read: array, then bypass, then R0 mask; all zero while clearing.
  always_comb begin
    r_data_a = reg_array[r_addr_a];
    if (byp_ok && (w_addr == r_addr_a)) r_data_a = w_data;
    if ((ZERO_R0 != 0) && ba_sel && (r_addr_a == '0)) r_data_a = '0;
    if (busy) r_data_a = '0;
  end

  // Port B read: array, then bypass; ba_sel has no effect here.
  always_comb begin
    r_data_b = reg_array[r_addr_b];
    if (byp_ok && (w_addr == r_addr_b)) r_data_b = w_data;
    if (busy) r_data_b = '0;
  end

endmodule
